fnd_sum_display: RTL
====================

Name: fnd_sum_display

Overview:
- Display-side consumer of the 8-bit adder result: takes the 8-bit sum and the carry-out as a 9-bit value (0..511).
- Converts the value to BCD with an iterative double-dabble FSM.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment (FND) display.
- Sits between the adder and the board FND pins.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. DIV = CLK_HZ/SCAN_HZ must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sum  input  8  adder sum, low 8 bits of the value.
- carry  input  1  adder carry-out, bit 8 of the value.
- busy  output  1  high while a BCD conversion is in progress.
- fnd_com  output  4  digit enables, active-low. Bit 0 = ones digit.
- fnd_font  output  8  segments, active-low. Bit 7 = dp, bits 6..0 = g..a.

Behaviour:
- Reset (async assert, sync release) clears: last_val=0, bcd_disp=0, FSM=IDLE, tick counter=0, digit_sel=0, busy=0.
  - Resulting outputs: fnd_com=4'b1110, fnd_font=8'hC0.
- val = {carry,sum}, 9 bits, sampled every cycle.
- Conversion FSM, states IDLE, SHIFT, DONE:
  - IDLE: if val != last_val at edge N, capture val into the shift register, set last_val<=val, go to SHIFT, busy<=1.
  - SHIFT: 9 edges (N+1..N+9). Each edge: every BCD nibble ≥5 gets +3, then shift left 1 with the next MSB of val.
  - DONE: edge N+10: bcd_disp<={hundreds,tens,ones}, busy<=0, return to IDLE.
  - Latency: display data is updated 10 edges after the change edge.
  - val changes while busy are ignored. The comparison in IDLE against last_val catches the final value after DONE, so no update is lost, but intermediate values may be skipped.
  - A value identical to last_val triggers no conversion.
- Scan:
  - Tick counter runs 0..DIV-1 and wraps. At the wrap edge, digit_sel increments mod 4 (3→0 wraps).
  - digit_sel 0 = ones, 1 = tens, 2 = hundreds, 3 = thousands (always 0).
  - fnd_com = ~(1<<digit_sel).
  - fnd_font = decode of the selected digit from registered digit_sel and bcd_disp, with dp always off.
- Font table, active-low, hex:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
  - Nibbles >9 cannot occur; decode them as FF.
- Exactly one fnd_com bit is low at all times after reset.
- Reset mid-conversion:
  - Aborts the conversion and forces the reset state.
  - After release, a nonzero val triggers a fresh conversion.
  - bcd_disp shows 0 until that conversion's DONE.

Optional Feature:
- Macro: FND_LZB_EN, leading-zero blanking.
- Defined:
  - Digit 3 is always FF.
  - Digit 2 is FF when hundreds==0.
  - Digit 1 is FF when hundreds==0 and tens==0.
  - Digit 0 is always shown.
  - Blanking is decided from bcd_disp, not from the in-flight conversion.
- Undefined: all four digits are shown; digit 3 shows C0.

Test Plan:
- Reset with sum=0, carry=0 → fnd_com=1110, fnd_font=C0, busy=0. Holding for 20 cycles gives no conversion (busy stays 0).
- CLK_HZ=40, SCAN_HZ=10, sum=8'hFE, carry=1 (510):
  - busy rises 1 edge after the change and falls at edge N+10.
  - Scan then gives: com 1110 / C0, 1101 / F9, 1011 / 92, 0111 / C0 (or FF with FND_LZB_EN).
  - Digit advances every 4 clocks and wraps 3→0.
- sum=8'h07, carry=0, with FND_LZB_EN → digit 0 shows F8; digits 1–3 show FF. Without the macro: C0, C0, C0.
- Change sum 8'h10→8'h20→8'h30 within one busy window → the display ends at 48 (digits 8, 4, 0) after a second conversion; busy pulses twice in total.
- Assert reset_n low during SHIFT while converting 300, then release → the display shows 0. With val held at 300, busy reasserts 1 edge after release and the display reads 3, 0, 0 after 10 edges.
- sum=8'hFF, carry=1 (511) → fonts 92 / F9 / F9 on digits 2 / 1 / 0.

Source files
------------

// File: rtl/fnd_sum_display_if.sv
// fnd_sum_display_if: groups the adder-result input and the FND-side outputs.
//
// Signalling contract: sum/carry are level inputs sampled on every rising
// clock edge, so there is no valid/ready pair. busy is high from the edge that
// accepts a new value until the edge that publishes its digits. Values that
// change while busy is high are not queued. Only the value present once busy
// drops is compared, and converted if it differs.
// state_dbg mirrors the conversion FSM state so checkers can bind to it.
interface fnd_sum_display_if;
   logic [7:0] sum;
   logic       carry;
   logic       busy;
   logic [3:0] fnd_com;
   logic [7:0] fnd_font;
   logic [1:0] state_dbg;

   modport master (
      output sum,
      output carry,
      input  busy,
      input  fnd_com,
      input  fnd_font,
      input  state_dbg
   );

   modport slave (
      input  sum,
      input  carry,
      output busy,
      output fnd_com,
      output fnd_font,
      output state_dbg
   );
endinterface

// File: rtl/fnd_sum_display.sv
// fnd_sum_display: turns the 9-bit adder result {carry,sum} into BCD with an
// iterative double-dabble FSM. It then drives a 4-digit common-anode
// multiplexed seven-segment display. Enables and segments are active-low.
// Optional macro FND_LZB_EN: leading-zero blanking of digits 3..1.
// DIV = CLK_HZ/SCAN_HZ must be at least 2.
module fnd_sum_display #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int SCAN_HZ = 1000
) (
   input  logic               clk,
   input  logic               reset_n,
   fnd_sum_display_if.slave   bus
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [8:0]        val;
   logic [8:0]        last_val;
   logic [8:0]        shreg;
   logic [11:0]       bcd_work;
   logic [11:0]       bcd_adj;
   logic [11:0]       bcd_disp;
   logic [3:0]        bit_cnt;
   logic [CNT_W-1:0]  tick_cnt;
   logic [1:0]        digit_sel;
   logic [3:0]        digit_nib;
   logic              blank;

   assign val = {bus.carry, bus.sum};

   function automatic logic [7:0] font_of(input logic [3:0] n);
      case (n)
         4'd0:    font_of = 8'hC0;
         4'd1:    font_of = 8'hF9;
         4'd2:    font_of = 8'hA4;
         4'd3:    font_of = 8'hB0;
         4'd4:    font_of = 8'h99;
         4'd5:    font_of = 8'h92;
         4'd6:    font_of = 8'h82;
         4'd7:    font_of = 8'hF8;
         4'd8:    font_of = 8'h80;
         4'd9:    font_of = 8'h90;
         default: font_of = 8'hFF;
      endcase
   endfunction

   // Conversion FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state: new value starts a run, nine shift steps, one publish step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (val != last_val) state_d = SHIFT;
         SHIFT:   if (bit_cnt == 4'd8) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
   always_comb begin
      bcd_adj = bcd_work;
      for (int i = 0; i < 3; i++) begin
         if (bcd_work[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      end
   end

   // Conversion datapath: capture, shift MSB-first into the BCD field, publish.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_val <= '0;
         shreg    <= '0;
         bcd_work <= '0;
         bcd_disp <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (val != last_val) begin
                  shreg    <= val;
                  last_val <= val;
                  bcd_work <= '0;
                  bit_cnt  <= '0;
               end
            end
            SHIFT: begin
               {bcd_work, shreg} <= {bcd_adj, shreg} << 1;
               bit_cnt           <= bit_cnt + 4'd1;
            end
            DONE:    bcd_disp <= bcd_work;
            default: ;
         endcase
      end
   end

   // Scan timebase: advance one digit every DIV clocks, wrapping 3 -> 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt  <= '0;
         digit_sel <= '0;
      end else if (tick_cnt == CNT_W'(DIV - 1)) begin
         tick_cnt  <= '0;
         digit_sel <= digit_sel + 2'd1;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Pick the nibble for the active digit. The thousands digit is always zero.
   always_comb begin
      digit_nib = 4'd0;
      case (digit_sel)
         2'd0:    digit_nib = bcd_disp[3:0];
         2'd1:    digit_nib = bcd_disp[7:4];
         2'd2:    digit_nib = bcd_disp[11:8];
         default: digit_nib = 4'd0;
      endcase
   end

   // Leading-zero blanking, judged from the published digits only.
   always_comb begin
      blank = 1'b0;
`ifdef FND_LZB_EN
      case (digit_sel)
         2'd3:    blank = 1'b1;
         2'd2:    blank = (bcd_disp[11:8] == 4'd0);
         2'd1:    blank = (bcd_disp[11:8] == 4'd0) && (bcd_disp[7:4] == 4'd0);
         default: blank = 1'b0;
      endcase
`else
      blank = 1'b0;
`endif
   end

   assign bus.fnd_com   = ~(4'b0001 << digit_sel);
   assign bus.fnd_font  = blank ? 8'hFF : font_of(digit_nib);
   assign bus.busy      = (state_q != IDLE);
   assign bus.state_dbg = state_q;

endmodule
